alu_operand_sequencer: RTL and testbench

Multi-cycle front end for the datapath ALU: holds the 8-entry general register file, fetches and optionally shifts two operands into staging registers, drives the ALU's `Ain`/`Bin`/`ALUop` inputs, captures its result and 3-bit status, and writes the result back. It sits directly upstream of the ALU, consuming its `out`/`Z` in the same cycle it drives it. One command is in flight at a time, under a start/done handshake.

---
 rtl/alu_operand_sequencer_pkg.sv | 34 +++
 rtl/alu_operand_sequencer_operand_shifter.sv | 24 ++
 rtl/alu_operand_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: widths, op/shift
// encodings and the command state machine states.
package alu_operand_sequencer_pkg;

   localparam int SEQ_DATA_W = 16;
   localparam int SEQ_NREG   = 8;
   localparam int SEQ_IDX_W  = 3;

   // ALU operation encodings, as understood by the downstream ALU
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_AND  = 2'b10,
      OP_NOTB = 2'b11
   } alu_op_e;

   // One-position shifts applied to the B operand on its way to staging
   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   // One command walks IDLE -> RDA -> RDB -> EXEC -> WB -> IDLE
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RDA  = 3'd1,
      ST_RDB  = 3'd2,
      ST_EXEC = 3'd3,
      ST_WB   = 3'd4
   } state_e;

endpackage

// File: rtl/alu_operand_sequencer_operand_shifter.sv
// Combinational single-position shifter for the B operand path.
module alu_operand_sequencer_operand_shifter
   import alu_operand_sequencer_pkg::*;
#(
   parameter int DATA_W = SEQ_DATA_W
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        shift_i,
   output logic [DATA_W-1:0] data_o
);

   // Select pass-through, logical left/right or arithmetic right by one bit
   always_comb begin
      data_o = data_i;
      case (shift_i)
         SH_NONE: data_o = data_i;
         SH_LSL1: data_o = {data_i[DATA_W-2:0], 1'b0};
         SH_LSR1: data_o = {1'b0, data_i[DATA_W-1:1]};
         SH_ASR1: data_o = {data_i[DATA_W-1], data_i[DATA_W-1:1]};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle operand front end for the datapath ALU: register file,
// operand staging, result/status capture and write-back.
module alu_operand_sequencer
   import alu_operand_sequencer_pkg::*;
#(
   parameter int DATA_W = SEQ_DATA_W,
   parameter int NREG   = SEQ_NREG
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [1:0]           aluop,
   input  logic [SEQ_IDX_W-1:0] rn,
   input  logic [SEQ_IDX_W-1:0] rm,
   input  logic [SEQ_IDX_W-1:0] rd,
   input  logic [1:0]           shift,
   input  logic                 wb_en,
   input  logic                 ld_en,
   input  logic [SEQ_IDX_W-1:0] ld_addr,
   input  logic [DATA_W-1:0]    ld_data,
   output logic [DATA_W-1:0]    alu_ain,
   output logic [DATA_W-1:0]    alu_bin,
   output logic [1:0]           alu_op,
   input  logic [DATA_W-1:0]    alu_out,
   input  logic [2:0]           alu_z,
   output logic [DATA_W-1:0]    c_out,
   output logic [2:0]           status,
   output logic                 busy,
   output logic                 done
);

   state_e state_q, state_d;

   // Latched command fields
   logic [1:0]           op_q;
   logic [SEQ_IDX_W-1:0] rn_q, rm_q, rd_q;
   logic [1:0]           shift_q;
   logic                 wb_en_q;

   // Operand staging, result and status
   logic [DATA_W-1:0] a_q, b_q, c_q;
   logic [2:0]        status_q;

   // General register file (flops: it must clear on reset)
   logic [DATA_W-1:0] regs_q [NREG];

   // Per-state strobes from the controller
   logic cmd_latch, ld_write, a_load, b_load, c_load, wb_write;

   logic [DATA_W-1:0] b_raw, b_shifted;

   assign b_raw = regs_q[rm_q];

   alu_operand_sequencer_operand_shifter #(
      .DATA_W (DATA_W)
   ) u_shifter (
      .data_i  (b_raw),
      .shift_i (shift_q),
      .data_o  (b_shifted)
   );

   // State register; reset aborts any command in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-state strobes
   always_comb begin
      state_d   = state_q;
      busy      = 1'b1;
      done      = 1'b0;
      cmd_latch = 1'b0;
      ld_write  = 1'b0;
      a_load    = 1'b0;
      b_load    = 1'b0;
      c_load    = 1'b0;
      wb_write  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy     = 1'b0;
            ld_write = ld_en;
            if (start) begin
               cmd_latch = 1'b1;
               state_d   = ST_RDA;
            end
         end
         ST_RDA: begin
            a_load  = 1'b1;
            state_d = ST_RDB;
         end
         ST_RDB: begin
            b_load  = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            c_load  = 1'b1;
            state_d = ST_WB;
         end
         ST_WB: begin
            done     = 1'b1;
            wb_write = wb_en_q;
            state_d  = ST_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Command latch, operand staging and result/status capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= 2'b00;
         rn_q     <= '0;
         rm_q     <= '0;
         rd_q     <= '0;
         shift_q  <= 2'b00;
         wb_en_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= 3'b000;
      end else begin
         if (cmd_latch) begin
            op_q    <= aluop;
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            shift_q <= shift;
            wb_en_q <= wb_en;
         end
         if (a_load) begin
            a_q <= regs_q[rn_q];
         end
         if (b_load) begin
            b_q <= b_shifted;
         end
         if (c_load) begin
            c_q      <= alu_out;
            status_q <= alu_z;
         end
      end
   end

   // Register file writes: direct loads in IDLE, result write-back in WB
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (ld_write) begin
            regs_q[ld_addr] <= ld_data;
         end
         if (wb_write) begin
            regs_q[rd_q] <= c_q;
         end
      end
   end

   assign alu_ain = a_q;
   assign alu_bin = b_q;
   assign alu_op  = op_q;
   assign c_out   = c_q;
   assign status  = status_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: supplies a behavioural ALU, a
// transaction-level model of registers and outputs, and directed commands.
module tb_alu_operand_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  aluop = 2'b00;
   logic [2:0]  rn = 3'd0, rm = 3'd0, rd = 3'd0;
   logic [1:0]  shift = 2'b00;
   logic        wb_en = 1'b0;
   logic        ld_en = 1'b0;
   logic [2:0]  ld_addr = 3'd0;
   logic [15:0] ld_data = 16'd0;
   logic [15:0] alu_ain, alu_bin, alu_out, c_out;
   logic [1:0]  alu_op;
   logic [2:0]  alu_z, status;
   logic        busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   alu_operand_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .aluop   (aluop),
      .rn      (rn),
      .rm      (rm),
      .rd      (rd),
      .shift   (shift),
      .wb_en   (wb_en),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .alu_ain (alu_ain),
      .alu_bin (alu_bin),
      .alu_op  (alu_op),
      .alu_out (alu_out),
      .alu_z   (alu_z),
      .c_out   (c_out),
      .status  (status),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Returns {overflow, negative, zero, result}
   function automatic logic [18:0] alu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      int sa, sb, full;
      logic [15:0] r;
      logic v;
      sa = $signed(a);
      sb = $signed(b);
      v = 1'b0;
      full = 0;
      case (op)
         2'b00: begin full = sa + sb; v = (full > 32767) || (full < -32768); end
         2'b01: begin full = sa - sb; v = (full > 32767) || (full < -32768); end
         default: full = 0;
      endcase
      case (op)
         2'b00, 2'b01: r = full[15:0];
         2'b10:        r = a & b;
         default:      r = ~b;
      endcase
      return {v, r[15], (r == 16'h0000), r};
   endfunction

   function automatic logic [15:0] shf(input logic [1:0] sh, input logic [15:0] v);
      int x;
      x = v;
      case (sh)
         2'b01: x = (x * 2) % 65536;
         2'b10: x = x / 2;
         2'b11: x = x / 2 + ((v >= 16'h8000) ? 32768 : 0);
         default: x = v;
      endcase
      return x[15:0];
   endfunction

   // External ALU stand-in
   always_comb {alu_z, alu_out} = alu_fn(alu_op, alu_ain, alu_bin);

   // Model: register contents plus previous/current command output values
   logic [15:0] m_regs [8];
   logic [15:0] cur_a = 0, cur_b = 0, cur_c = 0, prv_a = 0, prv_b = 0, prv_c = 0;
   logic [1:0]  cur_op = 0, prv_op = 0;
   logic [2:0]  cur_s = 0, prv_s = 0;
   int issue_cyc = -1000;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      cur_a = 0; cur_b = 0; cur_c = 0; cur_op = 0; cur_s = 0;
      prv_a = 0; prv_b = 0; prv_c = 0; prv_op = 0; prv_s = 0;
      issue_cyc = cyc - 1000;
   endtask

   // Single compare process: outputs follow from cycles elapsed since start
   always @(negedge clk) begin
      int k;
      k = cyc - issue_cyc;
      chk("busy",    busy,    (k >= 1 && k <= 4));
      chk("done",    done,    (k == 4));
      chk("alu_op",  alu_op,  (k >= 1) ? cur_op : prv_op);
      chk("alu_ain", alu_ain, (k >= 2) ? cur_a : prv_a);
      chk("alu_bin", alu_bin, (k >= 3) ? cur_b : prv_b);
      chk("c_out",   c_out,   (k >= 4) ? cur_c : prv_c);
      chk("status",  status,  (k >= 4) ? cur_s : prv_s);
   end

   task automatic load(input logic [2:0] a, input logic [15:0] v);
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = a; ld_data = v;
      m_regs[a] = v;
      @(posedge clk); #1;
      ld_en = 1'b0;
      $display("load R%0d <= %h", a, v);
   endtask

   task automatic cmd(input logic [1:0] op, input logic [2:0] n, input logic [2:0] m,
                      input logic [2:0] d, input logic [1:0] sh, input logic wb,
                      input logic do_ld, input logic [2:0] la, input logic [15:0] lv,
                      input logic intrude, input logic abort);
      logic [18:0] res;
      @(posedge clk); #1;
      start = 1'b1; aluop = op; rn = n; rm = m; rd = d; shift = sh; wb_en = wb;
      if (do_ld) begin
         ld_en = 1'b1; ld_addr = la; ld_data = lv;
         m_regs[la] = lv;
      end
      prv_a = cur_a; prv_b = cur_b; prv_c = cur_c; prv_op = cur_op; prv_s = cur_s;
      cur_op = op;
      cur_a = m_regs[n];
      cur_b = shf(sh, m_regs[m]);
      res = alu_fn(op, cur_a, cur_b);
      cur_c = res[15:0];
      cur_s = res[18:16];
      if (wb) m_regs[d] = cur_c;
      issue_cyc = cyc;
      @(posedge clk); #1;                       // RDA
      start = 1'b0; ld_en = 1'b0;
      @(posedge clk); #1;                       // RDB
      if (intrude) begin
         start = 1'b1; aluop = ~op; ld_en = 1'b1; ld_addr = 3'd0; ld_data = 16'hFFFF;
      end
      @(posedge clk); #1;                       // EXEC
      start = 1'b0; ld_en = 1'b0;
      chk("done_before_wb", done, 1'b0);
      if (abort) begin
         reset_n = 1'b0;
         model_reset();
         @(posedge clk); #1;
         reset_n = 1'b1;
         $display("cmd op=%0d rn=%0d rm=%0d aborted by reset", op, n, m);
         return;
      end
      @(posedge clk); #1;                       // WB
      chk("done_at_wb", done, 1'b1);
      @(posedge clk); #1;                       // back in IDLE
      $display("cmd op=%0d rn=%0d rm=%0d rd=%0d sh=%0d wb=%0d -> c=%h st=%b", op, n, m, d, sh, wb, c_out, status);
   endtask

   task automatic rd_reg(input logic [2:0] r, input logic [15:0] exp);
      cmd(2'b10, r, r, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("readback", c_out, exp);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // SUB 2 - 5, written to R2
      load(3'd0, 16'h0002);
      load(3'd1, 16'h0005);
      cmd(2'b01, 3'd0, 3'd1, 3'd2, 2'b00, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("sub_c", c_out, 16'hFFFD);
      chk("sub_st", status, 3'b010);
      rd_reg(3'd2, 16'hFFFD);

      // ADD with B shifted left
      cmd(2'b00, 3'd0, 3'd1, 3'd3, 2'b01, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("lsl_b", alu_bin, 16'h000A);
      chk("add_c", c_out, 16'h000C);
      chk("add_st", status, 3'b000);

      // Signed overflow, then arithmetic shift right of B
      load(3'd3, 16'h8000);
      load(3'd4, 16'h0001);
      cmd(2'b01, 3'd3, 3'd4, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("ovf_c", c_out, 16'h7FFF);
      chk("ovf_st", status, 3'b100);
      load(3'd4, 16'h8000);
      cmd(2'b01, 3'd3, 3'd4, 3'd0, 2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("asr_b", alu_bin, 16'hC000);
      chk("asr_c", c_out, 16'hC000);
      chk("asr_st", status, 3'b010);

      // NOT-B of a logically right-shifted operand
      cmd(2'b11, 3'd0, 3'd3, 3'd0, 2'b10, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("lsr_b", alu_bin, 16'h4000);
      chk("notb_c", c_out, 16'hBFFF);

      // Self-subtract with write-back disabled
      load(3'd5, 16'h1234);
      cmd(2'b01, 3'd5, 3'd5, 3'd5, 2'b00, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("zero_c", c_out, 16'h0000);
      chk("zero_st", status, 3'b001);
      rd_reg(3'd5, 16'h1234);

      // Load and start in the same IDLE cycle: RDA sees the new value
      cmd(2'b10, 3'd6, 3'd6, 3'd0, 2'b00, 1'b0, 1'b1, 3'd6, 16'h00F0, 1'b0, 1'b0);
      chk("ldstart_c", c_out, 16'h00F0);

      // Start and load during RDB are ignored
      cmd(2'b00, 3'd0, 3'd1, 3'd7, 2'b00, 1'b1, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
      chk("intr_c", c_out, 16'h0007);
      rd_reg(3'd0, 16'h0002);
      rd_reg(3'd7, 16'h0007);

      // Reset during EXEC clears everything, no done
      cmd(2'b00, 3'd0, 3'd1, 3'd1, 2'b00, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
      chk("rst_c", c_out, 16'h0000);
      chk("rst_st", status, 3'b000);
      chk("rst_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) rd_reg(i[2:0], 16'h0000);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
